// File: rtl/hcms_rx_if.sv
// HCMS-29xx receiver bundle: serial link pins in, column-write bus out.
// The master drives the link and observes the bus; the slave is the receiver.
interface hcms_rx_if #(
    parameter int ADDR_W = 5
);
    logic              i_hcms_data;
    logic              i_hcms_clock;
    logic              i_hcms_regsel;
    logic              i_hcms_ncs;
    logic              i_hcms_reset;
    logic              o_dot_we;
    logic [ADDR_W-1:0] o_dot_addr;
    logic [7:0]        o_dot_data;
    logic [6:0]        o_ctrl0;
    logic [1:0]        o_ctrl1;
    logic              o_busy;
    logic [7:0]        o_frame_cnt;
    logic              o_overrun;
    logic              o_err;

    modport slave (
        input  i_hcms_data, i_hcms_clock, i_hcms_regsel,
        input  i_hcms_ncs, i_hcms_reset,
        output o_dot_we, o_dot_addr, o_dot_data,
        output o_ctrl0, o_ctrl1, o_busy,
        output o_frame_cnt, o_overrun, o_err
    );

    modport master (
        output i_hcms_data, i_hcms_clock, i_hcms_regsel,
        output i_hcms_ncs, i_hcms_reset,
        input  o_dot_we, o_dot_addr, o_dot_data,
        input  o_ctrl0, o_ctrl1, o_busy,
        input  o_frame_cnt, o_overrun, o_err
    );
endinterface

// File: rtl/hcms_rx.sv
// HCMS-29xx display-side receiver: oversampled serial capture, dot/control
// latching on chip-enable release, and a one-column-per-cycle frame stream.
module hcms_rx #(
    parameter int NUM_COLS    = 20,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = $clog2(NUM_COLS)
) (
    input logic      i_CLK,
    input logic      i_nRST,
    hcms_rx_if.slave bus
);
    localparam int DOT_W = NUM_COLS * 8;
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(NUM_COLS - 1);
    // Pin vector order: {reset, ncs, regsel, clock, data}; idle link state.
    localparam logic [4:0] PIN_IDLE = 5'b11000;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_t;

    logic [4:0]       pins;
    logic [4:0]       sync_q [SYNC_STAGES];
    logic [4:0]       prev_q;
    logic [4:0]       cur;

    logic             soft_rst;
    logic             clk_rise;
    logic             ncs_fall;
    logic             ncs_rise;
    logic             dot_latch;
    logic             ctrl_latch;

    logic [7:0]       bit_cnt_q;
    logic [DOT_W-1:0] dot_sr_q;
    logic [7:0]       ctrl_sr_q;

    logic [6:0]       ctrl0_q;
    logic [1:0]       ctrl1_q;
    logic             err_q;
    logic [7:0]       frame_cnt_q;

    state_t           state_q;
    logic [ADDR_W-1:0] col_q;
    logic [DOT_W-1:0] snap_q;
    logic             we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]       data_q;
    logic             busy_q;
    logic             overrun_q;

    assign pins = {bus.i_hcms_reset, bus.i_hcms_ncs, bus.i_hcms_regsel,
                   bus.i_hcms_clock, bus.i_hcms_data};

    // Synchronizer chain on all link pins plus one edge-detect register.
    always_ff @(posedge i_CLK or negedge i_nRST) begin
        if (!i_nRST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= PIN_IDLE;
            end
            prev_q <= PIN_IDLE;
        end else begin
            sync_q[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Edge events decoded from the synchronized pins.
    always_comb begin
        cur        = sync_q[SYNC_STAGES-1];
        soft_rst   = ~cur[4];
        clk_rise   = cur[1] & ~prev_q[1] & ~cur[3];
        ncs_fall   = ~cur[3] & prev_q[3];
        ncs_rise   = cur[3] & ~prev_q[3];
        dot_latch  = ncs_rise & ~cur[2] & (|bit_cnt_q) & ~soft_rst;
        ctrl_latch = ncs_rise & cur[2] & (|bit_cnt_q) & ~soft_rst;
    end

    // Bit counter and the dot/control shift registers.
    always_ff @(posedge i_CLK or negedge i_nRST) begin
        if (!i_nRST) begin
            bit_cnt_q <= '0;
            dot_sr_q  <= '0;
            ctrl_sr_q <= '0;
        end else if (soft_rst) begin
            bit_cnt_q <= '0;
            dot_sr_q  <= '0;
            ctrl_sr_q <= '0;
        end else if (ncs_fall) begin
            bit_cnt_q <= '0;
        end else if (clk_rise) begin
            if (bit_cnt_q != 8'hFF) begin
                bit_cnt_q <= bit_cnt_q + 8'd1;
            end
            if (cur[2]) begin
                ctrl_sr_q <= {ctrl_sr_q[6:0], cur[0]};
            end else begin
                dot_sr_q <= {dot_sr_q[DOT_W-2:0], cur[0]};
            end
        end
    end

    // Control words, frame counter and sticky framing error.
    always_ff @(posedge i_CLK or negedge i_nRST) begin
        if (!i_nRST) begin
            ctrl0_q     <= '0;
            ctrl1_q     <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else if (soft_rst) begin
            ctrl0_q <= '0;
            ctrl1_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (dot_latch) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
                if (|bit_cnt_q[2:0]) begin
                    err_q <= 1'b1;
                end
            end
            if (ctrl_latch) begin
                if (bit_cnt_q == 8'd8) begin
                    if (ctrl_sr_q[7]) begin
                        ctrl1_q <= ctrl_sr_q[1:0];
                    end else begin
                        ctrl0_q <= ctrl_sr_q[6:0];
                    end
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // Column stream FSM; a new latch always restarts from column 0.
    always_ff @(posedge i_CLK or negedge i_nRST) begin
        if (!i_nRST) begin
            state_q   <= ST_IDLE;
            col_q     <= '0;
            snap_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else if (soft_rst) begin
            state_q   <= ST_IDLE;
            col_q     <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            case (state_q)
                ST_STREAM: begin
                    we_q   <= 1'b1;
                    busy_q <= 1'b1;
                    addr_q <= col_q;
                    data_q <= snap_q[DOT_W-1 -: 8];
                    snap_q <= snap_q << 8;
                    col_q  <= col_q + 1'b1;
                    if (col_q == LAST_COL) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
            if (dot_latch) begin
                snap_q    <= dot_sr_q;
                col_q     <= '0;
                state_q   <= ST_STREAM;
                overrun_q <= (state_q == ST_STREAM);
            end
        end
    end

    assign bus.o_dot_we    = we_q;
    assign bus.o_dot_addr  = addr_q;
    assign bus.o_dot_data  = data_q;
    assign bus.o_ctrl0     = ctrl0_q;
    assign bus.o_ctrl1     = ctrl1_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_frame_cnt = frame_cnt_q;
    assign bus.o_overrun   = overrun_q;
    assign bus.o_err       = err_q;
endmodule

// File: tb/tb_hcms_rx.sv
// Bench for hcms_rx: control-word table, directed multi-cycle corners and
// randomized frames against a bit-window model of the display.
module tb_hcms_rx;
    localparam int NC = 20;
    localparam int SS = 2;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hcms_rx_if #(.ADDR_W(AW)) bus ();

    hcms_rx #(.NUM_COLS(NC), .SYNC_STAGES(SS), .ADDR_W(AW)) dut (
        .i_CLK (clk),
        .i_nRST(rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Cycle counter and output monitor.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } strb_t;
    strb_t strbs[$];
    int fc_cyc = 0, ov_cyc = 0, ov_cnt = 0, busy_bad = 0;
    logic [7:0] last_fc = 8'd0;

    always @(negedge clk) begin
        if (bus.o_dot_we)
            strbs.push_back('{cyc, int'(bus.o_dot_addr), int'(bus.o_dot_data)});
        if (bus.o_overrun) begin
            ov_cnt++;
            ov_cyc = cyc;
        end
        if (bus.o_frame_cnt != last_fc) fc_cyc = cyc;
        last_fc = bus.o_frame_cnt;
        if (bus.o_busy !== bus.o_dot_we) busy_bad++;
    end

    // Reference model: the dot register is the last NC*8 dot bits received.
    bit       mdot[$];
    bit [7:0] mctrl_sr;
    bit [6:0] m_c0;
    bit [1:0] m_c1;
    bit       m_err;
    bit [7:0] m_fc;
    bit [7:0] m_col[NC];
    bit       m_soft = 0;
    bit       txq[$];
    bit       exp_stream;
    int       rise_cyc;

    function automatic void m_clear(input bit keep_fc);
        mdot.delete();
        repeat (NC * 8) mdot.push_back(1'b0);
        mctrl_sr = '0;
        m_c0 = '0;
        m_c1 = '0;
        m_err = 1'b0;
        if (!keep_fc) m_fc = '0;
    endfunction

    function automatic bit m_frame(input bit rs);
        int n = txq.size();
        int cnt = (n > 255) ? 255 : n;
        if (m_soft) return 1'b0;
        foreach (txq[i]) begin
            if (!rs) begin
                mdot.push_back(txq[i]);
                void'(mdot.pop_front());
            end else begin
                mctrl_sr = {mctrl_sr[6:0], txq[i]};
            end
        end
        if (n == 0) return 1'b0;
        if (!rs) begin
            m_fc++;
            if (cnt % 8 != 0) m_err = 1'b1;
            for (int k = 0; k < NC; k++)
                for (int b = 0; b < 8; b++)
                    m_col[k] = {m_col[k][6:0], mdot[8*k+b]};
            return 1'b1;
        end
        if (cnt == 8) begin
            if (mctrl_sr[7]) m_c1 = mctrl_sr[1:0];
            else m_c0 = mctrl_sr[6:0];
        end else begin
            m_err = 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_byte(input bit [7:0] v);
        for (int i = 7; i >= 0; i--) txq.push_back(v[i]);
    endtask

    task automatic rand_bits(input int n);
        txq.delete();
        repeat (n) txq.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic send_frame(input bit rs);
        bus.i_hcms_regsel = rs;
        tick(1);
        bus.i_hcms_ncs = 1'b0;
        tick(4);
        foreach (txq[i]) begin
            bus.i_hcms_data = txq[i];
            tick(2);
            bus.i_hcms_clock = 1'b1;
            tick(4);
            bus.i_hcms_clock = 1'b0;
            tick(4);
        end
        bus.i_hcms_ncs = 1'b1;
        rise_cyc = cyc;
        exp_stream = m_frame(rs);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_ctrl0"}, bus.o_ctrl0, m_c0);
        check({tag, "_ctrl1"}, bus.o_ctrl1, m_c1);
        check({tag, "_err"}, bus.o_err, m_err);
        check({tag, "_fcnt"}, bus.o_frame_cnt, m_fc);
    endtask

    task automatic check_stream(input string tag, input int from);
        check({tag, "_nstrb"}, strbs.size() - from, NC);
        for (int k = 0; k < NC && from + k < strbs.size(); k++) begin
            check({tag, "_addr"}, strbs[from+k].addr, k);
            check({tag, "_data"}, strbs[from+k].data, m_col[k]);
            check({tag, "_gap"}, strbs[from+k].cyc - strbs[from].cyc, k);
        end
    endtask

    task automatic run_frame(input bit rs, input string tag);
        strbs.delete();
        send_frame(rs);
        tick(NC + 10);
        check_status(tag);
        check({tag, "_busy"}, bus.o_busy, 0);
        if (exp_stream) begin
            check_stream(tag, 0);
            check({tag, "_first"},
                  strbs.size() > 0 ? strbs[0].cyc - fc_cyc : -1, 1);
        end else begin
            check({tag, "_nostrb"}, strbs.size(), 0);
        end
    endtask

    typedef struct {
        bit        rs;
        int        nbits;
        bit [15:0] val;
        bit [6:0]  c0;
        bit [1:0]  c1;
        bit        err;
    } vec_t;
    vec_t tbl[6];

    bit [7:0] font[NC] = '{8'h7E, 8'h11, 8'h11, 8'h11, 8'h7E,
                           8'h7F, 8'h49, 8'h49, 8'h49, 8'h36,
                           8'h3E, 8'h41, 8'h41, 8'h41, 8'h22,
                           8'h7F, 8'h41, 8'h41, 8'h22, 8'h1C};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bit [7:0] col_a[NC];
        int fc0, n_at, rc, npre;

        bus.i_hcms_data   = 1'b0;
        bus.i_hcms_clock  = 1'b0;
        bus.i_hcms_regsel = 1'b0;
        bus.i_hcms_ncs    = 1'b1;
        bus.i_hcms_reset  = 1'b1;
        m_clear(0);

        tbl = '{'{1'b1, 8, 16'h0081, 7'h00, 2'b01, 1'b0},
                '{1'b1, 8, 16'h007F, 7'h7F, 2'b01, 1'b0},
                '{1'b1, 8, 16'h0082, 7'h7F, 2'b10, 1'b0},
                '{1'b1, 8, 16'h0005, 7'h05, 2'b10, 1'b0},
                '{1'b1, 0, 16'h0000, 7'h05, 2'b10, 1'b0},
                '{1'b1, 9, 16'h01FF, 7'h05, 2'b10, 1'b1}};

        // Reset state.
        tick(3);
        check("rst_we", bus.o_dot_we, 0);
        check("rst_addr", bus.o_dot_addr, 0);
        check("rst_data", bus.o_dot_data, 0);
        check("rst_ctrl0", bus.o_ctrl0, 0);
        check("rst_ctrl1", bus.o_ctrl1, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_fcnt", bus.o_frame_cnt, 0);
        check("rst_ovr", bus.o_overrun, 0);
        check("rst_err", bus.o_err, 0);
        rst_n = 1'b1;
        tick(3);

        // Control word table.
        foreach (tbl[i]) begin
            txq.delete();
            for (int j = tbl[i].nbits - 1; j >= 0; j--)
                txq.push_back(tbl[i].val[j]);
            run_frame(tbl[i].rs, "tbl");
            check("tbl_c0", bus.o_ctrl0, tbl[i].c0);
            check("tbl_c1", bus.o_ctrl1, tbl[i].c1);
            check("tbl_err", bus.o_err, tbl[i].err);
        end

        // Display reset clears control and error.
        bus.i_hcms_reset = 1'b0;
        tick(SS + 3);
        m_clear(1);
        check("srst_c0", bus.o_ctrl0, 0);
        check("srst_c1", bus.o_ctrl1, 0);
        check("srst_err", bus.o_err, 0);
        check("srst_fcnt", bus.o_frame_cnt, 0);
        bus.i_hcms_reset = 1'b1;
        tick(SS + 3);

        // Full font frame.
        txq.delete();
        foreach (font[i]) push_byte(font[i]);
        run_frame(1'b0, "full");
        check("full_fcnt", bus.o_frame_cnt, 1);
        check("full_err", bus.o_err, 0);
        check("full_lat", fc_cyc - rise_cyc, SS + 1);
        foreach (font[i])
            if (i < strbs.size())
                check("full_font", strbs[i].data, font[i]);

        // 13-bit dot frame, then a short control frame; error sticks.
        rand_bits(13);
        run_frame(1'b0, "d13");
        check("d13_err", bus.o_err, 1);
        rand_bits(9);
        run_frame(1'b1, "c9");
        txq.delete();
        push_byte(8'h03);
        run_frame(1'b1, "c8");
        check("c8_err", bus.o_err, 1);
        check("c8_c0", bus.o_ctrl0, 7'h03);

        // Second latch lands on column 7 of the running stream.
        txq.delete();
        repeat (NC) push_byte(8'($urandom));
        strbs.delete();
        ov_cnt = 0;
        fc0 = int'(bus.o_frame_cnt);
        send_frame(1'b0);
        col_a = m_col;
        tick(1);
        bus.i_hcms_ncs = 1'b0;
        bus.i_hcms_data = 1'b1;
        tick(1);
        bus.i_hcms_clock = 1'b1;
        tick(3);
        bus.i_hcms_clock = 1'b0;
        tick(3);
        bus.i_hcms_ncs = 1'b1;
        txq.delete();
        txq.push_back(1'b1);
        void'(m_frame(1'b0));
        tick(NC + 10);
        check("ovr_cnt", ov_cnt, 1);
        check("ovr_at_latch", ov_cyc, fc_cyc);
        check("ovr_fcnt", bus.o_frame_cnt, 8'(fc0 + 2));
        npre = 0;
        foreach (strbs[i]) if (strbs[i].cyc <= ov_cyc) npre++;
        check("ovr_pre", npre, 8);
        for (int k = 0; k < npre && k < NC; k++)
            check("ovr_pre_data", strbs[k].data, col_a[k]);
        check_stream("ovr_post", npre);
        check("ovr_restart", strbs.size() > npre ? strbs[npre].cyc - ov_cyc : -1, 1);
        check_status("ovr");

        // Display reset in the middle of a stream.
        txq.delete();
        repeat (NC) push_byte(8'($urandom));
        strbs.delete();
        send_frame(1'b0);
        tick(SS + 6);
        bus.i_hcms_reset = 1'b0;
        rc = cyc;
        tick(SS + 2);
        n_at = strbs.size();
        m_clear(1);
        m_soft = 1'b1;
        check("mid_last_strb", n_at > 0 ? strbs[n_at-1].cyc - rc : -1, SS);
        txq.delete();
        push_byte(8'h7F);
        send_frame(1'b1);
        tick(5);
        check("mid_nostrb", strbs.size(), n_at);
        check("mid_we", bus.o_dot_we, 0);
        check("mid_busy", bus.o_busy, 0);
        check_status("mid");
        bus.i_hcms_reset = 1'b1;
        m_soft = 1'b0;
        tick(SS + 3);

        // Async reset in the middle of a stream.
        txq.delete();
        push_byte(8'h83);
        run_frame(1'b1, "pre_nrst");
        txq.delete();
        repeat (NC) push_byte(8'($urandom));
        send_frame(1'b0);
        tick(SS + 6);
        check("nrst_pre_we", bus.o_dot_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("nrst_we", bus.o_dot_we, 0);
        check("nrst_addr", bus.o_dot_addr, 0);
        check("nrst_data", bus.o_dot_data, 0);
        check("nrst_ctrl0", bus.o_ctrl0, 0);
        check("nrst_ctrl1", bus.o_ctrl1, 0);
        check("nrst_busy", bus.o_busy, 0);
        check("nrst_fcnt", bus.o_frame_cnt, 0);
        check("nrst_ovr", bus.o_overrun, 0);
        check("nrst_err", bus.o_err, 0);
        tick(3);
        rst_n = 1'b1;
        m_clear(0);
        tick(3);

        // Randomized frames against the model.
        for (int r = 0; r < 12; r++) begin
            bit rs = 1'($urandom_range(0, 1));
            int n;
            if (rs) begin
                n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : 8;
            end else begin
                case ($urandom_range(0, 2))
                    0: n = NC * 8;
                    1: n = 8 * $urandom_range(1, 6);
                    default: n = $urandom_range(0, 30);
                endcase
            end
            rand_bits(n);
            run_frame(rs, "rnd");
        end

        check("busy_eq_we", busy_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
